// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: 32x4 RAM with debounced-press writes and auto-scanned reads.
// Optional macro RAM_SCAN_WR_FWD_EN forwards write data to a same-address read.
module ram_scan_ctrl #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_key,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              pause,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr_r,
  output logic [DATA_W-1:0] data_out,
  output logic              wr_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              w_key_rise;
  logic              w_latch;
  logic              w_we;
  logic [ADDR_W-1:0] r_addr_w;
  logic [DATA_W-1:0] r_data_in;
  logic [ADDR_W-1:0] r_addr_r;
  logic [DATA_W-1:0] r_data_out;
  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_mem [DEPTH];

  assign w_key_rise = r_s2 & ~r_s3;

  // Synchronize the raw key and keep a delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= wr_key;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Write FSM next state: one write per press, then wait for release
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_we        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_key_rise) begin
          w_state_nxt = S_WRITE;
          w_latch     = 1'b1;
        end
      end
      S_WRITE: begin
        w_we        = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!r_s2) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture switch address/data only on an accepted press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_w  <= '0;
      r_data_in <= '0;
    end else if (w_latch) begin
      r_addr_w  <= sw_addr;
      r_data_in <= sw_data;
    end
  end

  // Memory array; cleared by reset so a mid-write reset leaves nothing behind
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[r_addr_w] <= r_data_in;
    end
  end

  // Scan divider; pause freezes both the count and the read address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div    <= '0;
      r_addr_r <= '0;
    end else if (!pause) begin
      if (r_div == DIV_LAST) begin
        r_div    <= '0;
        r_addr_r <= r_addr_r + ADDR_W'(1);
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  // Registered read of the current scan address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
    end else begin
`ifdef RAM_SCAN_WR_FWD_EN
      if (w_we && (r_addr_w == r_addr_r)) r_data_out <= r_data_in;
      else                                r_data_out <= r_mem[r_addr_r];
`else
      r_data_out <= r_mem[r_addr_r];
`endif
    end
  end

  assign addr_w   = r_addr_w;
  assign data_in  = r_data_in;
  assign addr_r   = r_addr_r;
  assign data_out = r_data_out;
  assign wr_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// tb_ram_scan_ctrl: directed bench for ram_scan_ctrl at SCAN_DIV = 4.
// Expected values are hand-derived from the timing of each scenario.
module tb_ram_scan_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_key;
  logic [4:0] sw_addr;
  logic [3:0] sw_data;
  logic       pause;
  logic [4:0] addr_w;
  logic [3:0] data_in;
  logic [4:0] addr_r;
  logic [3:0] data_out;
  logic       wr_busy;

  int n_pass;
  int n_total;

  ram_scan_ctrl #(
    .DATA_W  (4),
    .ADDR_W  (5),
    .SCAN_DIV(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_key  (wr_key),
    .sw_addr (sw_addr),
    .sw_data (sw_data),
    .pause   (pause),
    .addr_w  (addr_w),
    .data_in (data_in),
    .addr_r  (addr_r),
    .data_out(data_out),
    .wr_busy (wr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [4:0] a);
    int k;
    k = 0;
    while (addr_r !== a && k < 200) begin
      tick(1);
      k++;
    end
    n_total++;
    if (addr_r !== a)
      $display("FAIL wait_addr: addr_r=%h required %h", addr_r, a);
    else
      n_pass++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wr_key  = 1'b0;
    sw_addr = '0;
    sw_data = '0;
    pause   = 1'b0;
    tick(3);
    n_total++;
    if ({addr_w, data_in, addr_r, data_out, wr_busy} !== 19'd0)
      $display("FAIL reset_outs: got %h required 0",
               {addr_w, data_in, addr_r, data_out, wr_busy});
    else n_pass++;
    reset_n = 1'b1;
    tick(3);
    n_total++;
    if (addr_r !== 5'd0)
      $display("FAIL reset_addr3: addr_r=%h required 00", addr_r);
    else n_pass++;
    tick(1);
    n_total++;
    if (addr_r !== 5'd1)
      $display("FAIL reset_addr4: addr_r=%h required 01", addr_r);
    else n_pass++;
    n_total++;
    if (data_out !== 4'd0)
      $display("FAIL reset_dout: data_out=%h required 0", data_out);
    else n_pass++;
  endtask

  task automatic test_single_write;
    sw_addr = 5'h0A;
    sw_data = 4'h7;
    wr_key  = 1'b1;
    tick(2);
    n_total++;
    if (wr_busy !== 1'b0 || addr_w !== 5'h00)
      $display("FAIL sw_edge2: busy=%b addr_w=%h required 0/00",
               wr_busy, addr_w);
    else n_pass++;
    tick(1);
    n_total++;
    if (wr_busy !== 1'b1 || addr_w !== 5'h0A || data_in !== 4'h7)
      $display("FAIL sw_edge3: busy=%b addr_w=%h data_in=%h required 1/0A/7",
               wr_busy, addr_w, data_in);
    else n_pass++;
    tick(7);
    wr_key = 1'b0;
    tick(2);
    n_total++;
    if (wr_busy !== 1'b1)
      $display("FAIL sw_busy_hold: busy=%b required 1", wr_busy);
    else n_pass++;
    tick(1);
    n_total++;
    if (wr_busy !== 1'b0)
      $display("FAIL sw_busy_idle: busy=%b required 0", wr_busy);
    else n_pass++;
    wait_addr(5'h0A);
    n_total++;
    if (data_out !== 4'h0)
      $display("FAIL sw_dout_lag: data_out=%h required 0", data_out);
    else n_pass++;
    tick(1);
    n_total++;
    if (data_out !== 4'h7)
      $display("FAIL sw_dout: data_out=%h required 7", data_out);
    else n_pass++;
  endtask

  task automatic test_long_press;
    int rises;
    logic prev;
    rises   = 0;
    prev    = wr_busy;
    sw_addr = 5'h0A;
    sw_data = 4'h7;
    wr_key  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) sw_data = 4'h3;
      tick(1);
      if (wr_busy && !prev) rises++;
      prev = wr_busy;
    end
    n_total++;
    if (wr_busy !== 1'b1 || data_in !== 4'h7)
      $display("FAIL lp_hold: busy=%b data_in=%h required 1/7",
               wr_busy, data_in);
    else n_pass++;
    wr_key = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (wr_busy && !prev) rises++;
      prev = wr_busy;
    end
    n_total++;
    if (rises !== 1)
      $display("FAIL lp_writes: writes=%0d required 1", rises);
    else n_pass++;
    wait_addr(5'h0A);
    tick(1);
    n_total++;
    if (data_out !== 4'h7)
      $display("FAIL lp_mem: data_out=%h required 7", data_out);
    else n_pass++;
  endtask

  task automatic test_wrap_pause;
    wait_addr(5'd31);
    tick(3);
    n_total++;
    if (addr_r !== 5'd31)
      $display("FAIL wrap_pre: addr_r=%h required 1F", addr_r);
    else n_pass++;
    tick(1);
    n_total++;
    if (addr_r !== 5'd0)
      $display("FAIL wrap: addr_r=%h required 00", addr_r);
    else n_pass++;
    tick(2);
    pause = 1'b1;
    tick(10);
    pause = 1'b0;
    n_total++;
    if (addr_r !== 5'd0)
      $display("FAIL pause_hold: addr_r=%h required 00", addr_r);
    else n_pass++;
    tick(1);
    n_total++;
    if (addr_r !== 5'd0)
      $display("FAIL pause_late: addr_r=%h required 00", addr_r);
    else n_pass++;
    tick(1);
    n_total++;
    if (addr_r !== 5'd1)
      $display("FAIL pause_step: addr_r=%h required 01", addr_r);
    else n_pass++;
  endtask

  task automatic test_collision;
    logic [3:0] exp_first;
`ifdef RAM_SCAN_WR_FWD_EN
    exp_first = 4'hF;
`else
    exp_first = 4'h7;
`endif
    wait_addr(5'h09);
    tick(1);
    sw_addr = 5'h0A;
    sw_data = 4'hF;
    wr_key  = 1'b1;
    tick(3);
    n_total++;
    if (addr_r !== 5'h0A || wr_busy !== 1'b1 || data_out !== 4'h0)
      $display("FAIL col_setup: addr_r=%h busy=%b dout=%h required 0A/1/0",
               addr_r, wr_busy, data_out);
    else n_pass++;
    tick(1);
    n_total++;
    if (data_out !== exp_first)
      $display("FAIL col_first: data_out=%h required %h",
               data_out, exp_first);
    else n_pass++;
    tick(1);
    n_total++;
    if (data_out !== 4'hF)
      $display("FAIL col_second: data_out=%h required F", data_out);
    else n_pass++;
    wr_key = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_mid_write;
    sw_addr = 5'h15;
    sw_data = 4'hC;
    wr_key  = 1'b1;
    tick(3);
    n_total++;
    if (wr_busy !== 1'b1 || addr_w !== 5'h15)
      $display("FAIL rmw_write: busy=%b addr_w=%h required 1/15",
               wr_busy, addr_w);
    else n_pass++;
    reset_n = 1'b0;
    wr_key  = 1'b0;
    #1;
    n_total++;
    if ({addr_w, data_in, addr_r, data_out, wr_busy} !== 19'd0)
      $display("FAIL rmw_async: got %h required 0",
               {addr_w, data_in, addr_r, data_out, wr_busy});
    else n_pass++;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    n_total++;
    if (wr_busy !== 1'b0)
      $display("FAIL rmw_idle: busy=%b required 0", wr_busy);
    else n_pass++;
    wait_addr(5'h0A);
    tick(1);
    n_total++;
    if (data_out !== 4'h0)
      $display("FAIL rmw_clear: mem[0A]=%h required 0", data_out);
    else n_pass++;
    wait_addr(5'h15);
    tick(1);
    n_total++;
    if (data_out !== 4'h0)
      $display("FAIL rmw_target: mem[15]=%h required 0", data_out);
    else n_pass++;
  endtask

  task automatic test_key_held_reset;
    reset_n = 1'b0;
    sw_addr = 5'h03;
    sw_data = 4'h5;
    wr_key  = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    n_total++;
    if (wr_busy !== 1'b1 || addr_w !== 5'h03 || data_in !== 4'h5)
      $display("FAIL held_write: busy=%b addr_w=%h data_in=%h required 1/03/5",
               wr_busy, addr_w, data_in);
    else n_pass++;
    wr_key = 1'b0;
    tick(4);
    wait_addr(5'h03);
    tick(1);
    n_total++;
    if (data_out !== 4'h5)
      $display("FAIL held_mem: mem[03]=%h required 5", data_out);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset;
    test_single_write;
    test_long_press;
    test_wrap_pause;
    test_collision;
    test_reset_mid_write;
    test_key_held_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
